cbus_mem_responder: RTL

Memory-side responder for the cached bus (CBus). It accepts the `cbus_req_t` bursts that the core's `cache_manage` issues on `oreq`, and answers with `cbus_resp_t` beats backed by an internal word-addressed RAM. It sits at the far end of the CPU top's bus port and serves as the behavioural main memory for core-level simulation and for FPGA bring-up without a DDR controller. A configurable first-beat latency and an external stall input let the bench exercise the initiator's wait and backpressure handling.

---
 rtl/cbus_mem_responder_if.sv | 27 ++
 rtl/cbus_mem_responder.sv | 99 +++++++++
 2 files changed

// File: rtl/cbus_mem_responder_if.sv
// CBus request/response bundle between a cache-side initiator and a memory responder.
// The initiator drives creq; the responder answers on cresp.
interface cbus_mem_responder_if;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport master (output creq, input cresp);
  modport slave (input creq, output cresp);

endinterface

// File: rtl/cbus_mem_responder.sv
// Behavioural CBus main memory: accepts one burst at a time, waits LATENCY cycles,
// then streams read data or applies strobed writes one beat per unstalled cycle.
module cbus_mem_responder #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 2
) (
  input logic                 clk,
  input logic                 resetn,
  input logic                 stall,
  cbus_mem_responder_if.slave cbus
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [3:0] LatCnt = 4'(LATENCY);

  typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

  state_e        state_q;
  logic          is_write_q;
  logic [3:0]    len_q;
  logic [3:0]    beat_q;
  logic [3:0]    wait_q;
  logic [AW-1:0] idx_q;

  logic [31:0] mem [MEM_WORDS];

  logic ready;
  logic last;
  logic beat_wr;

  assign ready   = (state_q == StBurst) && !stall;
  assign last    = ready && (beat_q == len_q);
  assign beat_wr = ready && is_write_q;

  // Combinational response so stall suppresses ready in the same cycle.
  always_comb begin
    cbus.cresp       = '0;
    cbus.cresp.ready = ready;
    cbus.cresp.last  = last;
    if (ready && !is_write_q) begin
      cbus.cresp.data = mem[idx_q];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      is_write_q <= 1'b0;
      len_q      <= '0;
      beat_q     <= '0;
      wait_q     <= '0;
      idx_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cbus.creq.valid) begin
            is_write_q <= cbus.creq.is_write;
            len_q      <= cbus.creq.len;
            idx_q      <= cbus.creq.addr[AW+1:2];
            beat_q     <= '0;
            wait_q     <= LatCnt;
            state_q    <= (LATENCY == 0) ? StBurst : StWait;
          end
        end
        StWait: begin
          wait_q <= wait_q - 4'd1;
          if (wait_q == 4'd1) begin
            state_q <= StBurst;
          end
        end
        StBurst: begin
          if (ready) begin
            idx_q  <= idx_q + AW'(1);
            beat_q <= beat_q + 4'd1;
            if (last) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM has no reset; a reset mid-burst returns to idle, which blocks further writes.
  always_ff @(posedge clk) begin
    if (beat_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (cbus.creq.strobe[b]) begin
          mem[idx_q][8*b +: 8] <= cbus.creq.data[8*b +: 8];
        end
      end
    end
  end

  logic unused_fields;
  assign unused_fields = ^{cbus.creq.size, cbus.creq.addr[1:0], cbus.creq.addr[31:AW+2]};

endmodule
